// File: rtl/pipe_pkg.sv
// pipe_pkg: shared widths, control bit indices and occupancy encoding for pipe_stage_skid.
package pipe_pkg;
   localparam int DATA_W_DEF    = 32;
   localparam int RD_W_DEF      = 5;
   localparam int CTRL_W_DEF    = 2;
   localparam int CNT_W_DEF     = 16;
   localparam int CTRL_REGWRITE = 0;
   localparam int CTRL_MEMTOREG = 1;
   typedef enum logic [1:0] {
      ST_EMPTY = 2'b00,
      ST_ONE   = 2'b01,
      ST_FULL  = 2'b11
   } state_e;
endpackage

// File: rtl/pipe_slot.sv
// pipe_slot: one payload register with valid flag; clear drops valid and control bits, data stays stale.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_W   = RD_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] d_alu,
   input  logic [DATA_W-1:0] d_rd_data,
   input  logic [RD_W-1:0]   d_rd_addr,
   input  logic [CTRL_W-1:0] d_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] q_alu,
   output logic [DATA_W-1:0] q_rd_data,
   output logic [RD_W-1:0]   q_rd_addr,
   output logic [CTRL_W-1:0] q_ctrl
);
   always_ff @(posedge clk_i)
      if (rst_i) begin
         valid     <= 1'b0;
         q_alu     <= '0;
         q_rd_data <= '0;
         q_rd_addr <= '0;
         q_ctrl    <= '0;
      end else if (clear) begin
         valid  <= 1'b0;
         q_ctrl <= '0;
      end else if (load) begin
         valid     <= 1'b1;
         q_alu     <= d_alu;
         q_rd_data <= d_rd_data;
         q_rd_addr <= d_rd_addr;
         q_ctrl    <= d_ctrl;
      end
endmodule

// File: rtl/pipe_stage_skid.sv
// pipe_stage_skid: valid/ready pipeline stage register with optional skid entry, flush, forwarding tap and stall counter.
module pipe_stage_skid
   import pipe_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int RD_W   = RD_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int SKID   = 1,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] alu_result_i,
   input  logic [DATA_W-1:0] rd_data_i,
   input  logic [RD_W-1:0]   rd_addr_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] alu_result_o,
   output logic [DATA_W-1:0] rd_data_o,
   output logic [RD_W-1:0]   rd_addr_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic              fwd_valid_o,
   output logic [RD_W-1:0]   fwd_addr_o,
   output logic [DATA_W-1:0] fwd_data_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);
   logic              main_v, main_ld, main_clr, skid_v;
   logic [DATA_W-1:0] main_alu, main_rd, skid_alu, skid_rd;
   logic [RD_W-1:0]   main_addr, skid_addr;
   logic [CTRL_W-1:0] main_ctrl, skid_ctrl;
   logic [CNT_W-1:0]  cnt;
   generate
      if (SKID != 0) begin : g_skid
         state_e st;
         logic   skid_ld, skid_clr;
         assign st       = state_e'({skid_v, main_v});
         assign ready_o  = !skid_v;
         // A full stage refills main from skid; otherwise main takes the input when empty or draining.
         assign main_ld  = st == ST_FULL ? ready_i : valid_i & (st == ST_EMPTY | ready_i);
         assign main_clr = flush_i | (st == ST_ONE & !valid_i & ready_i);
         assign skid_ld  = st == ST_ONE & valid_i & !ready_i;
         assign skid_clr = flush_i | (st == ST_FULL & ready_i);
         pipe_slot #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) u_skid (
            .clk_i     (clk_i),
            .rst_i     (rst_i),
            .load      (skid_ld),
            .clear     (skid_clr),
            .d_alu     (alu_result_i),
            .d_rd_data (rd_data_i),
            .d_rd_addr (rd_addr_i),
            .d_ctrl    (ctrl_i),
            .valid     (skid_v),
            .q_alu     (skid_alu),
            .q_rd_data (skid_rd),
            .q_rd_addr (skid_addr),
            .q_ctrl    (skid_ctrl)
         );
      end else begin : g_reg
         assign ready_o   = ready_i | !main_v;
         assign main_ld   = valid_i & ready_o;
         assign main_clr  = flush_i | (main_v & ready_i & !valid_i);
         assign skid_v    = 1'b0;
         assign skid_alu  = '0;
         assign skid_rd   = '0;
         assign skid_addr = '0;
         assign skid_ctrl = '0;
      end
   endgenerate
   pipe_slot #(.DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W)) u_main (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .load      (main_ld),
      .clear     (main_clr),
      .d_alu     (skid_v ? skid_alu : alu_result_i),
      .d_rd_data (skid_v ? skid_rd : rd_data_i),
      .d_rd_addr (skid_v ? skid_addr : rd_addr_i),
      .d_ctrl    (skid_v ? skid_ctrl : ctrl_i),
      .valid     (main_v),
      .q_alu     (main_alu),
      .q_rd_data (main_rd),
      .q_rd_addr (main_addr),
      .q_ctrl    (main_ctrl)
   );
   always_ff @(posedge clk_i)
      if (rst_i)
         cnt <= '0;
      else if (valid_o & !ready_i & ~&cnt)
         cnt <= cnt + 1'b1;
   assign valid_o      = main_v;
   assign alu_result_o = main_alu;
   assign rd_data_o    = main_rd;
   assign rd_addr_o    = main_addr;
   assign ctrl_o       = main_v ? main_ctrl : '0;
   assign fwd_valid_o  = valid_o & ctrl_o[CTRL_REGWRITE] & |rd_addr_o;
   assign fwd_addr_o   = rd_addr_o;
   assign fwd_data_o   = ctrl_o[CTRL_MEMTOREG] ? rd_data_o : alu_result_o;
   assign stall_cnt_o  = cnt;
endmodule
